adder_accumulator: RTL and testbench
====================================

Name: adder_accumulator

Overview:
- Downstream stage of the synchronous adder; consumes each adder result ({C,S}) through the same val/rdy handshake.
- Accumulates results into a wider running sum over a frame of up to NUM_BEATS beats, then presents the frame total with beat count and overflow flag.
- Frame ends on the NUM_BEATS-th beat, or early on a beat with last asserted.
- Output held under a val_out/rdy_out handshake to the next consumer.

Parameters:
- DATA_WIDTH, 4: width of S from the adder; each input beat is DATA_WIDTH+1 bits ({C,S}).
- NUM_BEATS, 4: maximum beats per frame; must be >= 1.
- ACC_WIDTH, 8: accumulator/SUM width; must be >= DATA_WIDTH+1.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- val_in  input  1  upstream beat valid (driven by adder val_out)
- rdy_in  output  1  ready to accept a beat (drives adder rdy_out)
- S  input  DATA_WIDTH  adder sum
- C  input  1  adder carry
- last  input  1  marks final beat of frame; sampled only on an accepted beat
- val_out  output  1  frame result valid
- rdy_out  input  1  downstream ready
- SUM  output  ACC_WIDTH  frame total, modulo 2^ACC_WIDTH
- BEATS  output  $clog2(NUM_BEATS+1)  number of beats in the frame
- OVF  output  1  sticky: the frame total exceeded 2^ACC_WIDTH-1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ACC; acc, cnt, SUM, BEATS, OVF = 0; val_out=0.
  - rdy_in=1 from the first cycle after deassertion.
  - Reset mid-frame discards the partial frame; no result is emitted.
- State ACC:
  - rdy_in=1, val_out=0.
  - Accept when val_in && rdy_in. Beat value = {C,S} zero-extended to ACC_WIDTH.
  - On accept: acc <= acc + beat (mod 2^ACC_WIDTH); cnt++. Overflow flag is set if the carry out of ACC_WIDTH is 1, or is already set.
  - Frame ends when cnt==NUM_BEATS-1 or last=1. At that edge:
    - SUM <= acc+beat, BEATS <= cnt+1, OVF <= overflow.
    - val_out <= 1; state <= HOLD.
  - Latency: val_out is high the cycle after the final beat is accepted.
- State HOLD:
  - rdy_in=0 (no beats accepted), val_out=1.
  - SUM, BEATS, OVF held stable while val_out=1 and rdy_out=0.
  - On rdy_out=1: val_out <= 0; acc, cnt, overflow cleared; state <= ACC. SUM/BEATS/OVF keep their last values (don't-care while val_out=0).
  - No same-cycle bypass. Minimum frame period is (beats + 1) cycles.
- rdy_in is a combinational decode of state only; it never depends on val_in.
- NUM_BEATS=1: every accepted beat is a frame; last is ignored.
- last on the NUM_BEATS-th beat behaves identically to last=0.
- val_in with X on S/C while rdy_in=0 must not affect state.

Decomposition:
- Shared package adder_pkg:
  - state enum acc_state_t {ACC, HOLD}
  - default DATA_WIDTH constant shared with the adder
  - beat_t typedef for {C,S}
- One sub-module, beat_counter:
  - parameterised modulo-NUM_BEATS counter with inc, clear and terminal-count outputs
  - same clk and active-low asynchronous rst
- FSM and accumulator are inline in adder_accumulator.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> val_out=0, rdy_in=1, SUM=0, BEATS=0, OVF=0.
- Full frame: defaults, 4 consecutive beats {C,S}=5'h1F -> cycle after the 4th accept: val_out=1, SUM=124, BEATS=4, OVF=0, rdy_in=0.
- Early last: beats 3 then 7 with last=1 on the second -> SUM=10, BEATS=2; next frame restarts from 0.
- Overflow: ACC_WIDTH=6, 4 beats of 5'h1F -> SUM=60 (124 mod 64), OVF=1, BEATS=4. The following frame of 4 beats of 1 gives SUM=4, OVF=0.
- Backpressure: frame complete, rdy_out=0 for 5 cycles with val_in=1 -> SUM/BEATS/OVF stable, rdy_in=0, no beats counted. Then rdy_out=1 -> val_out falls next edge, rdy_in=1, acc=0.
- Async reset mid-frame: assert rst=0 between clock edges after 2 beats -> val_out/SUM/OVF zero immediately without a clock edge. After release, a 4-beat frame of value 2 gives SUM=8, BEATS=4.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and defaults for the adder and its downstream accumulator stage.
package adder_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 4;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

  // One adder result as seen on the beat interface: {C,S}
  typedef struct packed {
    logic                          c;
    logic [DATA_WIDTH_DEFAULT-1:0] s;
  } beat_t;

endpackage

// File: rtl/beat_counter.sv
// Modulo-NUM_BEATS beat counter with synchronous clear and registered terminal count.
module beat_counter #(
  parameter int unsigned NUM_BEATS = 4,
  parameter int unsigned CNT_WIDTH = $clog2(NUM_BEATS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 tc_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NUM_BEATS - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tc_q, tc_d;

  // tc is precomputed from the next count so it stays a plain flop output
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_q ? '0 : cnt_q + CNT_WIDTH'(1);
    end
    tc_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tc_q  <= (NUM_BEATS == 1);
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc_q;

endmodule

// File: rtl/adder_accumulator.sv
// Accumulates adder results over frames of up to NUM_BEATS beats and presents
// the frame total, beat count and overflow flag under a val/rdy handshake.
module adder_accumulator
  import adder_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter  int unsigned NUM_BEATS   = 4,
  parameter  int unsigned ACC_WIDTH   = 8,
  localparam int unsigned BEATS_WIDTH = $clog2(NUM_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   val_in,
  output logic                   rdy_in,
  input  logic [DATA_WIDTH-1:0]  S,
  input  logic                   C,
  input  logic                   last,
  output logic                   val_out,
  input  logic                   rdy_out,
  output logic [ACC_WIDTH-1:0]   SUM,
  output logic [BEATS_WIDTH-1:0] BEATS,
  output logic                   OVF
);

  acc_state_t             state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_run_q, ovf_run_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic [BEATS_WIDTH-1:0] beats_q, beats_d;
  logic                   ovf_q, ovf_d;
  logic                   val_out_q, val_out_d;

  logic                   cnt_inc, cnt_clr, cnt_tc;
  logic [BEATS_WIDTH-1:0] cnt;
  logic [ACC_WIDTH-1:0]   beat_ext;
  logic [ACC_WIDTH:0]     sum_ext;

  beat_counter #(
    .NUM_BEATS (NUM_BEATS),
    .CNT_WIDTH (BEATS_WIDTH)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .clr_i (cnt_clr),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  // Top bit of sum_ext is the carry out of the accumulator width
  assign beat_ext = ACC_WIDTH'({C, S});
  assign sum_ext  = {1'b0, acc_q} + {1'b0, beat_ext};

  // Ready is a pure state decode so it never combinationally follows val_in
  assign rdy_in = (state_q == ACC);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_run_d = ovf_run_q;
    sum_d     = sum_q;
    beats_d   = beats_q;
    ovf_d     = ovf_q;
    val_out_d = val_out_q;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
      ACC: begin
        if (val_in) begin
          acc_d     = sum_ext[ACC_WIDTH-1:0];
          ovf_run_d = ovf_run_q | sum_ext[ACC_WIDTH];
          cnt_inc   = 1'b1;
          if (cnt_tc || last) begin
            sum_d     = sum_ext[ACC_WIDTH-1:0];
            beats_d   = cnt + BEATS_WIDTH'(1);
            ovf_d     = ovf_run_q | sum_ext[ACC_WIDTH];
            val_out_d = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (rdy_out) begin
          val_out_d = 1'b0;
          acc_d     = '0;
          ovf_run_d = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      ovf_run_q <= 1'b0;
      sum_q     <= '0;
      beats_q   <= '0;
      ovf_q     <= 1'b0;
      val_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_run_q <= ovf_run_d;
      sum_q     <= sum_d;
      beats_q   <= beats_d;
      ovf_q     <= ovf_d;
      val_out_q <= val_out_d;
    end
  end

  assign val_out = val_out_q;
  assign SUM     = sum_q;
  assign BEATS   = beats_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_adder_accumulator.sv
// Randomized self-checking bench for adder_accumulator; two instances
// (ACC_WIDTH 8 and 6) share stimulus and are checked against a frame-total model.
module tb_adder_accumulator;

  localparam int unsigned DW  = 4;
  localparam int unsigned NB  = 4;
  localparam int unsigned AWA = 8;
  localparam int unsigned AWB = 6;
  localparam int unsigned BW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          val_in;
  logic [DW-1:0] S;
  logic          C;
  logic          last;
  logic          rdy_out;

  logic           rdy_in_a, val_out_a, ovf_a;
  logic [AWA-1:0] sum_a;
  logic [BW-1:0]  beats_a;
  logic           rdy_in_b, val_out_b, ovf_b;
  logic [AWB-1:0] sum_b;
  logic [BW-1:0]  beats_b;

  int checks = 0;
  int passed = 0;
  int beat_vals[NB];

  always #5 clk = ~clk;

  adder_accumulator #(.DATA_WIDTH(DW), .NUM_BEATS(NB), .ACC_WIDTH(AWA)) dut_a (
    .clk(clk), .rst(rst), .val_in(val_in), .rdy_in(rdy_in_a), .S(S), .C(C),
    .last(last), .val_out(val_out_a), .rdy_out(rdy_out), .SUM(sum_a),
    .BEATS(beats_a), .OVF(ovf_a)
  );

  adder_accumulator #(.DATA_WIDTH(DW), .NUM_BEATS(NB), .ACC_WIDTH(AWB)) dut_b (
    .clk(clk), .rst(rst), .val_in(val_in), .rdy_in(rdy_in_b), .S(S), .C(C),
    .last(last), .val_out(val_out_b), .rdy_out(rdy_out), .SUM(sum_b),
    .BEATS(beats_b), .OVF(ovf_b)
  );

  // Drives one frame from beat_vals[0..n-1] starting at a falling edge, then
  // checks the result against the arithmetic total, holds it, and releases it.
  task automatic drive_frame(input string tag, input int n, input bit use_last,
                             input int gap_max, input int hold_cycles);
    int          total;
    int          exp_sa, exp_sb;
    bit          exp_oa, exp_ob;
    logic [4:0]  bv;
    total = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < int'($urandom_range(0, gap_max)); g++) begin
        val_in = 1'b0; {C, S} = 5'($urandom); last = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (rdy_in_a !== 1'b1 || rdy_in_b !== 1'b1)
        $display("FAIL %s rdy_in beat %0d: got %b/%b expected 1", tag, i, rdy_in_a, rdy_in_b);
      else passed++;
      bv = 5'(beat_vals[i]);
      val_in = 1'b1; {C, S} = bv; last = use_last && (i == n - 1);
      total += beat_vals[i];
      @(negedge clk);
    end
    val_in = 1'b0; last = 1'b0;
    exp_sa = total % 256; exp_oa = (total >= 256);
    exp_sb = total % 64;  exp_ob = (total >= 64);
    for (int h = 0; h <= hold_cycles; h++) begin
      checks++;
      if (val_out_a !== 1'b1 || val_out_b !== 1'b1 || rdy_in_a !== 1'b0 || rdy_in_b !== 1'b0)
        $display("FAIL %s hold%0d val_out/rdy_in: got %b%b/%b%b expected 10/10", tag, h,
                 val_out_a, rdy_in_a, val_out_b, rdy_in_b);
      else passed++;
      checks++;
      if (sum_a !== 8'(exp_sa) || beats_a !== 3'(n) || ovf_a !== exp_oa)
        $display("FAIL %s hold%0d W8 result: got sum=%0d beats=%0d ovf=%b expected sum=%0d beats=%0d ovf=%b",
                 tag, h, sum_a, beats_a, ovf_a, exp_sa, n, exp_oa);
      else passed++;
      checks++;
      if (sum_b !== 6'(exp_sb) || beats_b !== 3'(n) || ovf_b !== exp_ob)
        $display("FAIL %s hold%0d W6 result: got sum=%0d beats=%0d ovf=%b expected sum=%0d beats=%0d ovf=%b",
                 tag, h, sum_b, beats_b, ovf_b, exp_sb, n, exp_ob);
      else passed++;
      if (h < hold_cycles) begin
        val_in = 1'b1; {C, S} = 5'($urandom); last = 1'($urandom);
        @(negedge clk);
      end
    end
    rdy_out = 1'b1; val_in = 1'b0; last = 1'b0;
    @(negedge clk);
    rdy_out = 1'b0;
    checks++;
    if (val_out_a !== 1'b0 || val_out_b !== 1'b0 || rdy_in_a !== 1'b1 || rdy_in_b !== 1'b1)
      $display("FAIL %s release: got val_out=%b/%b rdy_in=%b/%b expected 0/0 1/1", tag,
               val_out_a, val_out_b, rdy_in_a, rdy_in_b);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0; val_in = 1'b0; S = '0; C = 1'b0; last = 1'b0; rdy_out = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (val_out_a !== 1'b0 || sum_a !== 8'd0 || beats_a !== 3'd0 || ovf_a !== 1'b0)
      $display("FAIL reset W8: got val=%b sum=%0d beats=%0d ovf=%b expected all 0",
               val_out_a, sum_a, beats_a, ovf_a);
    else passed++;
    checks++;
    if (val_out_b !== 1'b0 || sum_b !== 6'd0 || beats_b !== 3'd0 || ovf_b !== 1'b0)
      $display("FAIL reset W6: got val=%b sum=%0d beats=%0d ovf=%b expected all 0",
               val_out_b, sum_b, beats_b, ovf_b);
    else passed++;
    @(negedge clk);
    checks++;
    if (rdy_in_a !== 1'b1 || rdy_in_b !== 1'b1)
      $display("FAIL reset rdy_in: got %b/%b expected 1", rdy_in_a, rdy_in_b);
    else passed++;
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < int'(NB); i++) beat_vals[i] = 31;
    drive_frame("full_max", 4, 1'b0, 0, 0);
    for (int i = 0; i < int'(NB); i++) beat_vals[i] = 1;
    drive_frame("after_ovf", 4, 1'b0, 0, 0);
  endtask

  task automatic test_early_last();
    beat_vals[0] = 3; beat_vals[1] = 7;
    drive_frame("early_last", 2, 1'b1, 0, 0);
    beat_vals[0] = 1; beat_vals[1] = 2; beat_vals[2] = 3;
    drive_frame("restart", 3, 1'b1, 0, 0);
    beat_vals[0] = 20;
    drive_frame("single_beat", 1, 1'b1, 0, 0);
    beat_vals[0] = 4; beat_vals[1] = 5; beat_vals[2] = 6; beat_vals[3] = 7;
    drive_frame("last_on_final", 4, 1'b1, 0, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < int'(NB); i++) beat_vals[i] = 31;
    drive_frame("backpressure", 4, 1'b0, 0, 5);
    for (int i = 0; i < int'(NB); i++) beat_vals[i] = 2 * i + 1;
    drive_frame("post_bp", 4, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 40; f++) begin
      n = int'($urandom_range(1, NB));
      for (int i = 0; i < int'(NB); i++) beat_vals[i] = int'($urandom_range(0, 31));
      drive_frame("random", n, (n < int'(NB)) ? 1'b1 : 1'($urandom), 2,
                  int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < int'(NB); i++) beat_vals[i] = 31;
    drive_frame("pre_reset", 4, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      val_in = 1'b1; {C, S} = 5'd5; last = 1'b0;
      @(negedge clk);
    end
    val_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (val_out_a !== 1'b0 || sum_a !== 8'd0 || beats_a !== 3'd0 || ovf_a !== 1'b0)
      $display("FAIL async_rst W8: got val=%b sum=%0d beats=%0d ovf=%b expected all 0",
               val_out_a, sum_a, beats_a, ovf_a);
    else passed++;
    checks++;
    if (val_out_b !== 1'b0 || sum_b !== 6'd0 || beats_b !== 3'd0 || ovf_b !== 1'b0)
      $display("FAIL async_rst W6: got val=%b sum=%0d beats=%0d ovf=%b expected all 0",
               val_out_b, sum_b, beats_b, ovf_b);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < int'(NB); i++) beat_vals[i] = 2;
    drive_frame("post_rst", 4, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_early_last();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
